// File: rtl/xfft_frame_ctrl.sv
// Frame sequencer in front of the xfft core: sends one config beat, then gates
// NFRAMES frames of FFT_LEN samples with tlast, and tracks output frames and core events.
module xfft_frame_ctrl #(
  parameter int DATA_WID = 16,
  parameter int CONF_WID = 8,
  parameter int STAT_WID = 8,
  parameter int FFT_LEN  = 64,
  parameter int NFRAMES  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic [CONF_WID-1:0]            cfg_word,
  input  logic [2*DATA_WID-1:0]          s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [2*DATA_WID-1:0]          m_axis_data_tdata,
  output logic                           m_axis_data_tvalid,
  input  logic                           m_axis_data_tready,
  output logic                           m_axis_data_tlast,
  output logic [CONF_WID-1:0]            m_axis_config_tdata,
  output logic                           m_axis_config_tvalid,
  input  logic                           m_axis_config_tready,
  input  logic                           fft_out_tvalid,
  input  logic                           fft_out_tready,
  input  logic                           fft_out_tlast,
  input  logic                           event_tlast_unexpected,
  input  logic                           event_tlast_missing,
  input  logic                           event_fft_overflow,
  output logic                           busy,
  output logic                           done,
  output logic                           err,
  output logic [$clog2(NFRAMES+1)-1:0]   frames_in,
  output logic [$clog2(NFRAMES+1)-1:0]   frames_out,
  output logic [STAT_WID-1:0]            ovf_cnt
);

  localparam int SW = $clog2(FFT_LEN);
  localparam int FW = $clog2(NFRAMES+1);
  localparam logic [SW-1:0] SAMP_LAST = SW'(FFT_LEN - 1);
  localparam logic [FW-1:0] FR_MAX    = FW'(NFRAMES);
  localparam logic [FW-1:0] FR_LAST   = FW'(NFRAMES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_STREAM, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t              r_state, w_next;
  logic [CONF_WID-1:0] r_cfg;
  logic [SW-1:0]       r_samp_cnt;
  logic [FW-1:0]       r_frames_in, r_frames_out;
  logic [STAT_WID-1:0] r_ovf_cnt;
  logic                r_err;

  logic w_start, w_data_hs, w_frame_end;
  logic w_active, w_run, w_tlast_evt, w_out_frame, w_ovf_inc;

  function automatic logic [FW-1:0] sat_inc_frames(input logic [FW-1:0] v);
    return (v == FR_MAX) ? v : v + FW'(1);
  endfunction

  function automatic logic [STAT_WID-1:0] sat_inc_ovf(input logic [STAT_WID-1:0] v);
    return (v == '1) ? v : v + STAT_WID'(1);
  endfunction

  assign w_active    = (r_state == S_CFG) || (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_run       = (r_state == S_STREAM) || (r_state == S_DRAIN);
  assign w_tlast_evt = (event_tlast_unexpected | event_tlast_missing) & w_active;
  assign w_out_frame = fft_out_tvalid & fft_out_tready & fft_out_tlast & w_run;
  assign w_ovf_inc   = event_fft_overflow & w_run;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // STREAM is a zero-latency pass-through; every other state holds the data path closed.
  always_comb begin
    w_next               = r_state;
    w_start              = 1'b0;
    w_data_hs            = 1'b0;
    w_frame_end          = 1'b0;
    s_axis_tready        = 1'b0;
    m_axis_data_tvalid   = 1'b0;
    m_axis_data_tdata    = '0;
    m_axis_data_tlast    = 1'b0;
    m_axis_config_tvalid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en) begin
          w_start = 1'b1;
          w_next  = S_CFG;
        end
      end
      S_CFG: begin
        m_axis_config_tvalid = 1'b1;
        if (m_axis_config_tready) w_next = S_STREAM;
      end
      S_STREAM: begin
        s_axis_tready      = m_axis_data_tready;
        m_axis_data_tvalid = s_axis_tvalid;
        m_axis_data_tdata  = s_axis_tdata;
        m_axis_data_tlast  = (r_samp_cnt == SAMP_LAST);
        w_data_hs          = s_axis_tvalid & m_axis_data_tready;
        w_frame_end        = w_data_hs & m_axis_data_tlast;
        if (w_frame_end && ((r_frames_in == FR_LAST) || !en)) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_frames_out == r_frames_in) w_next = S_DONE;
      end
      S_DONE: begin
        if (!en) w_next = S_IDLE;
      end
      S_ERR: begin
        if (!en) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_tlast_evt) w_next = S_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg        <= '0;
      r_samp_cnt   <= '0;
      r_frames_in  <= '0;
      r_frames_out <= '0;
      r_ovf_cnt    <= '0;
      r_err        <= 1'b0;
    end else if (w_start) begin
      r_cfg        <= cfg_word;
      r_samp_cnt   <= '0;
      r_frames_in  <= '0;
      r_frames_out <= '0;
      r_ovf_cnt    <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_frame_end)    r_samp_cnt <= '0;
      else if (w_data_hs) r_samp_cnt <= r_samp_cnt + SW'(1);
      if (w_frame_end)    r_frames_in  <= r_frames_in + FW'(1);
      if (w_out_frame)    r_frames_out <= sat_inc_frames(r_frames_out);
      if (w_ovf_inc)      r_ovf_cnt    <= sat_inc_ovf(r_ovf_cnt);
      if (w_tlast_evt)    r_err        <= 1'b1;
    end
  end

  assign m_axis_config_tdata = r_cfg;
  assign busy       = w_active;
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign frames_in  = r_frames_in;
  assign frames_out = r_frames_out;
  assign ovf_cnt    = r_ovf_cnt;

endmodule

// File: tb/tb_xfft_frame_ctrl.sv
// Randomized bench for xfft_frame_ctrl: ADC source, FFT output model and a
// transaction-level reference (beat index, frame counts, overflow window).
module tb_xfft_frame_ctrl;

  localparam int DATA_WID = 16;
  localparam int CONF_WID = 8;
  localparam int STAT_WID = 8;
  localparam int FFT_LEN  = 64;
  localparam int NFRAMES  = 4;
  localparam int FW       = $clog2(NFRAMES+1);
  localparam int OVF_MAX  = (1 << STAT_WID) - 1;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   en = 1'b0;
  logic [CONF_WID-1:0]    cfg_word = '0;
  logic [2*DATA_WID-1:0]  s_axis_tdata = '0;
  logic                   s_axis_tvalid = 1'b0;
  logic                   s_axis_tready;
  logic [2*DATA_WID-1:0]  m_axis_data_tdata;
  logic                   m_axis_data_tvalid;
  logic                   m_axis_data_tready = 1'b0;
  logic                   m_axis_data_tlast;
  logic [CONF_WID-1:0]    m_axis_config_tdata;
  logic                   m_axis_config_tvalid;
  logic                   m_axis_config_tready = 1'b0;
  logic                   fft_out_tvalid = 1'b0;
  logic                   fft_out_tready = 1'b0;
  logic                   fft_out_tlast = 1'b0;
  logic                   event_tlast_unexpected = 1'b0;
  logic                   event_tlast_missing = 1'b0;
  logic                   event_fft_overflow = 1'b0;
  logic                   busy, done, err;
  logic [FW-1:0]          frames_in, frames_out;
  logic [STAT_WID-1:0]    ovf_cnt;

  always #5 clk = ~clk;

  xfft_frame_ctrl #(
    .DATA_WID(DATA_WID), .CONF_WID(CONF_WID), .STAT_WID(STAT_WID),
    .FFT_LEN(FFT_LEN), .NFRAMES(NFRAMES)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_word(cfg_word),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tvalid(m_axis_data_tvalid),
    .m_axis_data_tready(m_axis_data_tready), .m_axis_data_tlast(m_axis_data_tlast),
    .m_axis_config_tdata(m_axis_config_tdata), .m_axis_config_tvalid(m_axis_config_tvalid),
    .m_axis_config_tready(m_axis_config_tready),
    .fft_out_tvalid(fft_out_tvalid), .fft_out_tready(fft_out_tready), .fft_out_tlast(fft_out_tlast),
    .event_tlast_unexpected(event_tlast_unexpected), .event_tlast_missing(event_tlast_missing),
    .event_fft_overflow(event_fft_overflow),
    .busy(busy), .done(done), .err(err),
    .frames_in(frames_in), .frames_out(frames_out), .ovf_cnt(ovf_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // scenario knobs
  int p_vld, p_rdy, cfg_stall, drop_at, ovf_mode, err_at, err_kind;
  // reference state for the current run
  logic [2*DATA_WID-1:0] exp_q[$];
  logic [CONF_WID-1:0]   run_cfg;
  int  beats, cfg_beats, cfg_wait, fft_pending, fft_delay, ovf_model, exp_frames;
  bit  cfg_prev, cfg_seen, window, done_seen, err_fired, started, src_taken, fft_fire;

  task automatic init_run(input int pv, input int pr, input int stall, input int drop,
                          input int ovfm, input int eat, input int ekind);
    p_vld = pv; p_rdy = pr; cfg_stall = stall; drop_at = drop;
    ovf_mode = ovfm; err_at = eat; err_kind = ekind;
    exp_q.delete();
    beats = 0; cfg_beats = 0; cfg_wait = 0; fft_pending = 0; fft_delay = 0; ovf_model = 0;
    cfg_prev = 0; cfg_seen = 0; window = 0; done_seen = 0; err_fired = 0; started = 0;
    run_cfg  = CONF_WID'($urandom);
    cfg_word = run_cfg;
    if (drop < 0) exp_frames = NFRAMES;
    else exp_frames = (drop / FFT_LEN + 1 > NFRAMES) ? NFRAMES : drop / FFT_LEN + 1;
  endtask

  task automatic drive();
    if (!s_axis_tvalid || src_taken) begin
      s_axis_tvalid = ($urandom_range(99) < p_vld);
      s_axis_tdata  = (2*DATA_WID)'($urandom);
    end
    m_axis_data_tready   = ($urandom_range(99) < p_rdy);
    m_axis_config_tready = (cfg_wait >= cfg_stall);
    if (fft_delay > 0) fft_delay--;
    fft_fire = (fft_pending > 0) && (fft_delay == 0);
    if (fft_fire) begin
      fft_out_tvalid = 1'b1; fft_out_tready = 1'b1; fft_out_tlast = 1'b1;
    end else begin
      fft_out_tvalid = ($urandom_range(2) == 0);
      fft_out_tlast  = ($urandom_range(1) == 1);
      fft_out_tready = fft_out_tlast ? 1'b0 : ($urandom_range(1) == 1);
    end
    case (ovf_mode)
      0:       event_fft_overflow = 1'b0;
      1:       event_fft_overflow = ($urandom_range(3) == 0);
      default: event_fft_overflow = 1'b1;
    endcase
    if (started && drop_at >= 0 && beats >= drop_at) en = 1'b0;
    event_tlast_missing    = 1'b0;
    event_tlast_unexpected = 1'b0;
    if (started && err_at >= 0 && !err_fired && beats >= err_at) begin
      err_fired = 1;
      if (err_kind == 0) event_tlast_missing = 1'b1;
      else               event_tlast_unexpected = 1'b1;
    end
  endtask

  task automatic observe();
    bit hs, cfg_hs;
    src_taken = s_axis_tvalid && s_axis_tready;
    if (src_taken) exp_q.push_back(s_axis_tdata);
    if (cfg_prev) chk("cfg_hold", 32'(m_axis_config_tvalid), 1);
    if (m_axis_config_tvalid) begin
      chk("cfg_data", 32'(m_axis_config_tdata), 32'(run_cfg));
      cfg_wait++;
    end
    cfg_hs   = m_axis_config_tvalid && m_axis_config_tready;
    cfg_prev = m_axis_config_tvalid && !m_axis_config_tready;
    hs = m_axis_data_tvalid && m_axis_data_tready;
    if (hs) begin
      chk("cfg_before_data", 32'(cfg_seen), 1);
      chk("tlast_pos", 32'(m_axis_data_tlast), 32'((beats % FFT_LEN) == FFT_LEN - 1));
      if (exp_q.size() > 0) chk("data", m_axis_data_tdata, exp_q.pop_front());
      else chk("scoreboard_depth", 32'(exp_q.size()), 1);
      if (m_axis_data_tlast) fft_pending++;
      beats++;
    end
    if (fft_fire) begin
      fft_pending--;
      fft_delay = $urandom_range(10, 1);
    end
    if (window && !done && event_fft_overflow && ovf_model < OVF_MAX) ovf_model++;
    if (cfg_hs) begin
      cfg_beats++;
      cfg_seen = 1;
      window = 1;
    end
    if (done && !done_seen) begin
      done_seen = 1;
      window = 0;
      chk("done_frames_in", 32'(frames_in), exp_frames);
      chk("done_frames_out", 32'(frames_out), exp_frames);
      chk("done_ovf_cnt", 32'(ovf_cnt), ovf_model);
      chk("done_err", 32'(err), 0);
      chk("done_busy", 32'(busy), 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    observe();
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_s_tready"},   32'(s_axis_tready), 0);
    chk({pfx, "_m_tvalid"},   32'(m_axis_data_tvalid), 0);
    chk({pfx, "_m_tlast"},    32'(m_axis_data_tlast), 0);
    chk({pfx, "_cfg_tvalid"}, 32'(m_axis_config_tvalid), 0);
    chk({pfx, "_cfg_tdata"},  32'(m_axis_config_tdata), 0);
    chk({pfx, "_busy"},       32'(busy), 0);
    chk({pfx, "_done"},       32'(done), 0);
    chk({pfx, "_err"},        32'(err), 0);
    chk({pfx, "_frames_in"},  32'(frames_in), 0);
    chk({pfx, "_frames_out"}, 32'(frames_out), 0);
    chk({pfx, "_ovf_cnt"},    32'(ovf_cnt), 0);
  endtask

  task automatic run_capture();
    int cyc;
    en = 1'b1;
    started = 1;
    step();
    chk("start_busy", 32'(busy), 1);
    chk("start_err", 32'(err), 0);
    cfg_word = ~run_cfg;
    cyc = 0;
    while (!done_seen && cyc < 5000) begin
      step();
      cyc++;
    end
    chk("run_done_seen", 32'(done_seen), 1);
    chk("cfg_beats", cfg_beats, 1);
    chk("cfg_valid_cycles", cfg_wait, cfg_stall + 1);
    chk("beat_total", beats, exp_frames * FFT_LEN);
    chk("scoreboard_left", 32'(exp_q.size()), 0);
    en = 1'b0;
    step();
    step();
    chk("idle_done", 32'(done), 0);
    chk("idle_busy", 32'(busy), 0);
  endtask

  task automatic run_error();
    int cyc;
    en = 1'b1;
    started = 1;
    cyc = 0;
    while (!err_fired && cyc < 2000) begin
      step();
      cyc++;
    end
    chk("err_injected", 32'(err_fired), 1);
    step();
    chk("err_flag", 32'(err), 1);
    chk("err_busy", 32'(busy), 0);
    chk("err_s_tready", 32'(s_axis_tready), 0);
    chk("err_m_tvalid", 32'(m_axis_data_tvalid), 0);
    chk("err_done", 32'(done), 0);
    step();
    step();
    chk("err_hold", 32'(err), 1);
    chk("err_hold_s_tready", 32'(s_axis_tready), 0);
    en = 1'b0;
    step();
    step();
    chk("err_idle_sticky", 32'(err), 1);
    chk("err_idle_busy", 32'(busy), 0);
  endtask

  task automatic run_reset_mid();
    int cyc;
    en = 1'b1;
    started = 1;
    cyc = 0;
    while (beats < 70 && cyc < 2000) begin
      step();
      cyc++;
    end
    chk("mid_reached", 32'(beats >= 70), 1);
    rst = 1'b1;
    en  = 1'b0;
    step();
    check_reset("mid_rst");
    rst = 1'b0;
    step();
    check_reset("after_mid_rst");
  endtask

  initial begin
    p_vld = 0; p_rdy = 0; cfg_stall = 0; drop_at = -1; ovf_mode = 0; err_at = -1; err_kind = 0;
    src_taken = 0; fft_fire = 0; fft_pending = 0; fft_delay = 0; started = 0;
    step(); step(); step();
    check_reset("rst");
    rst = 1'b0;
    step();
    check_reset("post_rst");

    init_run(100, 100, 0, -1, 0, -1, 0); run_capture();   // nominal, continuous
    init_run(100, 100, 5, -1, 1, -1, 0); run_capture();   // config backpressure
    init_run(60, 70, 0, -1, 1, -1, 0);   run_capture();   // random gaps both sides
    init_run(80, 80, 0, 100, 1, -1, 0);  run_capture();   // en low at sample 100
    init_run(100, 100, 0, -1, 0, 30, 0); run_error();     // tlast_missing in STREAM
    init_run(100, 100, 0, -1, 2, -1, 0); run_capture();   // overflow held -> saturation
    init_run(70, 90, 4, 0, 0, -1, 0);    run_capture();   // en low while in CFG
    init_run(100, 100, 0, -1, 1, 5, 1);  run_error();     // tlast_unexpected
    init_run(90, 60, 0, -1, 1, -1, 0);   run_reset_mid();
    init_run(50, 50, 2, 170, 1, -1, 0);  run_capture();   // en low in frame 2

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/xfft_frame_ctrl.md
Name: xfft_frame_ctrl

Overview:
Sequencer between the ADC sample stream and the Xilinx xfft core. On enable it issues one configuration word on the FFT config channel, then gates a fixed number of FFT_LEN-sample frames into the core, inserting tlast on each frame boundary. It counts completed output frames and monitors the core's event flags. It reports done/error status to the capture logic (VIP) and to software.

Parameters:
DATA_WID, 16, bits per I/Q component; sample word is 2*DATA_WID
CONF_WID, 8, width of FFT config tdata
STAT_WID, 8, width of the overflow event counter
FFT_LEN, 64, samples per frame; power of two, >=8
NFRAMES, 4, frames per capture run; >=1

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  level run request
cfg_word  in  CONF_WID  config word (fwd/inv, scale schedule); latched on leaving IDLE
s_axis_tdata  in  2*DATA_WID  ADC samples
s_axis_tvalid  in  1  ADC sample valid
s_axis_tready  out  1  ready to ADC
m_axis_data_tdata  out  2*DATA_WID  samples to FFT
m_axis_data_tvalid  out  1  valid to FFT
m_axis_data_tready  in  1  FFT s_axis_data_tready
m_axis_data_tlast  out  1  frame boundary to FFT
m_axis_config_tdata  out  CONF_WID  config word to FFT
m_axis_config_tvalid  out  1  config valid
m_axis_config_tready  in  1  FFT config ready
fft_out_tvalid  in  1  FFT m_axis_data_tvalid (monitor only)
fft_out_tready  in  1  downstream tready on FFT output (monitor only)
fft_out_tlast  in  1  FFT m_axis_data_tlast (monitor only)
event_tlast_unexpected  in  1  FFT event
event_tlast_missing  in  1  FFT event
event_fft_overflow  in  1  FFT event
busy  out  1  state not IDLE/DONE/ERR
done  out  1  run complete
err  out  1  sticky tlast error
frames_in  out  $clog2(NFRAMES+1)  input frames accepted this run
frames_out  out  $clog2(NFRAMES+1)  output frames observed this run
ovf_cnt  out  STAT_WID  saturating overflow-event count

Behaviour:
- Reset: state=IDLE. All outputs 0: tvalid/tready/tlast/config_tvalid, busy, done, err, counters. Latched config = 0.
- States: IDLE, CFG, STREAM, DRAIN, DONE, ERR.
- IDLE: s_axis_tready=0, m_axis_data_tvalid=0. On en=1: latch cfg_word, clear samp_cnt, frames_in, frames_out, ovf_cnt, err; go to CFG the next cycle.
- CFG: m_axis_config_tvalid=1 with the latched word, held stable until tready. Handshake cycle -> STREAM next cycle. en dropping in CFG is ignored until the handshake completes.
- STREAM: combinational pass-through. m_axis_data_tvalid=s_axis_tvalid, s_axis_tready=m_axis_data_tready, tdata is a direct copy. Zero latency.
  - samp_cnt (log2 FFT_LEN bits) advances only on a data handshake. m_axis_data_tlast=1 when samp_cnt==FFT_LEN-1.
  - Handshake with tlast: samp_cnt wraps to 0 and frames_in increments.
  - Handshake with tlast that makes frames_in==NFRAMES, or with en==0 at that edge: go to DRAIN.
  - en low mid-frame: the current frame still completes. No partial frames are ever sent.
- DRAIN: s_axis_tready=0, m_axis_data_tvalid=0. Go to DONE when frames_out==frames_in.
- frames_out increments on fft_out_tvalid&fft_out_tready&fft_out_tlast in STREAM/DRAIN. Saturates at NFRAMES.
- DONE: done=1, counters hold. en==0 -> IDLE, which clears done. A new run needs en to go low then high.
- Errors:
  - event_tlast_unexpected or event_tlast_missing in CFG/STREAM/DRAIN: err=1 (sticky) and go to ERR next cycle.
  - ERR: datapath gated as in DRAIN, done=0. Leave to IDLE when en==0; err stays 1 until the next run start.
  - Tlast event and overflow on the same cycle: both are recorded.
- event_fft_overflow: ovf_cnt+=1 each asserted cycle in STREAM/DRAIN, saturating at 2^STAT_WID-1. It is not an error.
- busy=1 in CFG, STREAM, DRAIN.
- Reset mid-run: back to IDLE in one cycle. Outputs go to their reset values. The FFT core is reset separately by top-level rst.

Test Plan:
- Nominal, FFT_LEN=64, NFRAMES=4, tready held 1, continuous ADC: exactly one config beat carrying cfg_word; tlast on beats 63, 127, 191, 255; 256 data beats total; done=1 after 4 output tlasts; frames_in=frames_out=4.
- Config backpressure, config_tready held low for 5 cycles: config_tvalid held with stable tdata; no data beat before the config handshake.
- Random s_axis_tvalid and random m_axis_data_tready gaps: samp_cnt advances only on handshakes; tlast positions are still every 64th beat; no data is dropped or duplicated versus an input scoreboard.
- en dropped at sample 100 of run: frame 1 completes (tlast at beat 127); no further beats; DRAIN waits for 2 output frames; done=1 with frames_in=2.
- event_tlast_missing pulsed in STREAM: next cycle state=ERR, err=1, s_axis_tready=0; en low -> IDLE with err still 1; a new en rise clears err.
- event_fft_overflow held for 300 cycles with STAT_WID=8: ovf_cnt saturates at 255; the run still reaches done.
